decode_stage: RTL and testbench

- Decode/operand-fetch stage of the single-issue RV32 core; the producer side of the ALU interface.
- Accepts fetched instructions over a valid/ready handshake and decodes ADD and ADDI.
- Reads operands from an internal 32x32 register file with a writeback port and same-cycle bypass.
- Drives a registered output bundle: op1, op2, imm, is_add, is_addi, rd, illegal. The ALU consumes op1/op2/imm/is_add/is_addi; rd and illegal travel downstream to writeback.

---
 rtl/decode_stage.sv | 159 +++++++++++++++
 tb/tb_decode_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32 decode/operand-fetch stage (ADD/ADDI) with register file and bypass
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   in_valid, in_ready, instr   instruction input handshake
//   wb_en, wb_rd, wb_data       register file write port (accepted every cycle)
//   out_valid, out_ready        output bundle handshake
//   op1, op2, imm               ALU operands and sign-extended immediate
//   is_add, is_addi             decoded operation flags
//   rd, illegal                 destination index and unsupported-encoding flag
//   illegal_count               saturating count of accepted illegal instructions
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] op1,
    output logic [XLEN-1:0] op2,
    output logic [XLEN-1:0] imm,
    output logic            is_add,
    output logic            is_addi,
    output logic [4:0]      rd,
    output logic            illegal,
    output logic [15:0]     illegal_count
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    logic [XLEN-1:0] regs [NREGS];

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] dec_rd;

    logic            dec_add;
    logic            dec_addi;
    logic            dec_illegal;
    logic            wb_hit;
    logic            accept;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] nxt_op1;
    logic [XLEN-1:0] nxt_op2;
    logic [XLEN-1:0] nxt_imm;

    assign opcode = instr[6:0];
    assign dec_rd = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    assign imm_ext = {{(XLEN-12){instr[31]}}, instr[31:20]};

    assign dec_add     = (opcode == OPC_OP) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
    assign dec_addi    = (opcode == OPC_OP_IMM) && (funct3 == 3'b000);
    assign dec_illegal = !dec_add && !dec_addi;

    // A slot frees up either when it is empty or when its bundle leaves this cycle.
    assign in_ready = !reset && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Writes to x0 are dropped, so only a non-zero index can hit the bypass.
    assign wb_hit = wb_en && (wb_rd != 5'd0);

    // Operand read: x0 is hard-wired zero; a same-cycle writeback to the source
    // register wins over the stale array contents.
    always_comb begin
        rs1_val = '0;
        if (rs1 != 5'd0) begin
            if (wb_hit && (wb_rd == rs1)) begin
                rs1_val = wb_data;
            end else begin
                rs1_val = regs[rs1];
            end
        end
    end

    always_comb begin
        rs2_val = '0;
        if (rs2 != 5'd0) begin
            if (wb_hit && (wb_rd == rs2)) begin
                rs2_val = wb_data;
            end else begin
                rs2_val = regs[rs2];
            end
        end
    end

    // ADDI places rs1 on op2 because the ALU computes imm + op2.
    always_comb begin
        nxt_op1 = '0;
        nxt_op2 = '0;
        nxt_imm = '0;
        if (dec_add) begin
            nxt_op1 = rs1_val;
            nxt_op2 = rs2_val;
        end else if (dec_addi) begin
            nxt_op2 = rs1_val;
            nxt_imm = imm_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_hit) begin
            regs[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid     <= 1'b0;
            op1           <= '0;
            op2           <= '0;
            imm           <= '0;
            is_add        <= 1'b0;
            is_addi       <= 1'b0;
            rd            <= 5'd0;
            illegal       <= 1'b0;
            illegal_count <= 16'd0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                op1       <= nxt_op1;
                op2       <= nxt_op2;
                imm       <= nxt_imm;
                is_add    <= dec_add;
                is_addi   <= dec_addi;
                rd        <= dec_rd;
                illegal   <= dec_illegal;
                if (dec_illegal && (illegal_count != 16'hFFFF)) begin
                    illegal_count <= illegal_count + 16'd1;
                end
            end else if (out_ready) begin
                // Bundle consumed with nothing new to replace it; fields hold.
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage
module tb_decode_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    logic        is_add;
    logic        is_addi;
    logic [4:0]  rd;
    logic        illegal;
    logic [15:0] illegal_count;

    decode_stage #(.XLEN(32), .NREGS(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .op1(op1), .op2(op2), .imm(imm),
        .is_add(is_add), .is_addi(is_addi), .rd(rd),
        .illegal(illegal), .illegal_count(illegal_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
        logic        is_add;
        logic        is_addi;
        logic [4:0]  rd;
        logic        illegal;
    } bundle_t;

    typedef struct packed {
        logic        wb_en;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic [31:0] instr;
        bundle_t     exp;
    } vec_t;

    int tests  = 0;
    int failed = 0;

    logic [31:0] m_regs [32];
    logic        m_valid;
    bundle_t     m_bundle;
    int          m_cnt;

    function automatic bundle_t mk(logic [31:0] a, logic [31:0] b, logic [31:0] i,
                                   logic ad, logic ai, logic [4:0] r, logic il);
        bundle_t x;
        x.op1 = a; x.op2 = b; x.imm = i;
        x.is_add = ad; x.is_addi = ai; x.rd = r; x.illegal = il;
        return x;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_bundle(string tag, bundle_t e);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".op1"}, op1, e.op1);
        chk({tag, ".op2"}, op2, e.op2);
        chk({tag, ".imm"}, imm, e.imm);
        chk({tag, ".is_add"}, 32'(is_add), 32'(e.is_add));
        chk({tag, ".is_addi"}, 32'(is_addi), 32'(e.is_addi));
        chk({tag, ".rd"}, 32'(rd), 32'(e.rd));
        chk({tag, ".illegal"}, 32'(illegal), 32'(e.illegal));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference register read: x0 is zero, a live writeback to the same index wins.
    function automatic logic [31:0] m_read(int idx, logic we, logic [4:0] wr, logic [31:0] wd);
        if (idx == 0) return 32'd0;
        if (we && (int'(wr) == idx)) return wd;
        return m_regs[idx];
    endfunction

    function automatic bundle_t m_decode(logic [31:0] w, logic we, logic [4:0] wr, logic [31:0] wd);
        bundle_t b;
        int opc, f3, f7, s1, s2;
        logic [31:0] sw;
        opc = int'(w % 128);
        f3  = int'((w / 4096) % 8);
        f7  = int'(w / 33554432);
        s1  = int'((w / 32768) % 32);
        s2  = int'((w / 1048576) % 32);
        b = mk(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'((w / 128) % 32), 1'b0);
        if (opc == 'h33 && f3 == 0 && f7 == 0) begin
            b.is_add = 1'b1;
            b.op1 = m_read(s1, we, wr, wd);
            b.op2 = m_read(s2, we, wr, wd);
        end else if (opc == 'h13 && f3 == 0) begin
            b.is_addi = 1'b1;
            b.op2 = m_read(s1, we, wr, wd);
            sw = w;
            b.imm = 32'($signed(sw) >>> 20);
        end else begin
            b.illegal = 1'b1;
        end
        return b;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [4:0]  a, b, d;
        r = $urandom;
        a = 5'($urandom_range(0, 7));
        b = 5'($urandom_range(0, 7));
        d = 5'($urandom_range(0, 31));
        case ($urandom_range(0, 3))
            0: return {7'b0, b, a, 3'b000, d, 7'b0110011};
            1: return {r[31:20], a, 3'b000, d, 7'b0010011};
            2: return r;
            default: return {r[31:25], b, a, r[14:12], d, r[0] ? 7'b0110011 : 7'b0010011};
        endcase
    endfunction

    vec_t vecs [10];

    initial begin
        bundle_t e;
        logic    exp_ready;
        int      need;

        vecs[0] = '{1'b1, 5'd1, 32'd7,          32'h00500093, mk(0, 0, 5, 0, 1, 1, 0)};
        vecs[1] = '{1'b1, 5'd2, 32'd9,          32'h002081B3, mk(7, 9, 0, 1, 0, 3, 0)};
        vecs[2] = '{1'b1, 5'd1, 32'h10,         32'hFFF08113, mk(0, 32'h10, 32'hFFFFFFFF, 0, 1, 2, 0)};
        vecs[3] = '{1'b1, 5'd0, 32'h55,         32'h000001B3, mk(0, 0, 0, 1, 0, 3, 0)};
        vecs[4] = '{1'b0, 5'd0, 32'd0,          32'h402081B3, mk(0, 0, 0, 0, 0, 3, 1)};
        vecs[5] = '{1'b0, 5'd0, 32'd0,          32'h00110233, mk(9, 32'h10, 0, 1, 0, 4, 0)};
        vecs[6] = '{1'b0, 5'd0, 32'd0,          32'h00501093, mk(0, 0, 0, 0, 0, 1, 1)};
        vecs[7] = '{1'b0, 5'd0, 32'd0,          32'h7FF10293, mk(0, 9, 32'h7FF, 0, 1, 5, 0)};
        vecs[8] = '{1'b0, 5'd0, 32'd0,          32'h80010293, mk(0, 9, 32'hFFFFF800, 0, 1, 5, 0)};
        vecs[9] = '{1'b1, 5'd2, 32'hDEADBEEF,   32'h00210333, mk(32'hDEADBEEF, 32'hDEADBEEF, 0, 1, 0, 6, 0)};

        reset = 1'b1; in_valid = 1'b1; instr = 32'h002081B3;
        wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0; out_ready = 1'b1;
        step(); step();
        chk("rst.out_valid", 32'(out_valid), 0);
        chk("rst.in_ready", 32'(in_ready), 0);
        chk("rst.op1", op1, 0);
        chk("rst.imm", imm, 0);
        chk("rst.flags", {29'd0, is_add, is_addi, illegal}, 0);
        chk("rst.rd", 32'(rd), 0);
        chk("rst.illegal_count", 32'(illegal_count), 0);

        reset = 1'b0; in_valid = 1'b0;
        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd5;
        step();
        wb_en = 1'b0; in_valid = 1'b1; instr = 32'h00500093;
        #1 chk("first.in_ready", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        chk_bundle("first", mk(0, 0, 5, 0, 1, 1, 0));

        for (int i = 0; i < 10; i++) begin
            wb_en = vecs[i].wb_en; wb_rd = vecs[i].wb_rd; wb_data = vecs[i].wb_data;
            instr = vecs[i].instr; in_valid = 1'b1; out_ready = 1'b1;
            step();
            wb_en = 1'b0;
            chk_bundle($sformatf("vec%0d", i), vecs[i].exp);
        end
        chk("vec.illegal_count", 32'(illegal_count), 2);
        in_valid = 1'b0;
        step();
        chk("drain.out_valid", 32'(out_valid), 0);

        // Stall: ADD held while ADDI waits.
        instr = 32'h002081B3; in_valid = 1'b1; out_ready = 1'b0;
        step();
        instr = 32'h00500093;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("stall%0d.in_ready", i), 32'(in_ready), 0);
            step();
            chk_bundle($sformatf("stall%0d", i), mk(32'h10, 32'hDEADBEEF, 0, 1, 0, 3, 0));
        end
        out_ready = 1'b1;
        #1 chk("release.in_ready", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        chk_bundle("release", mk(0, 0, 5, 0, 1, 1, 0));
        step();
        chk("release.no_dup", 32'(out_valid), 0);

        // Reset while a bundle is stalled.
        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'h77;
        instr = 32'h402081B3; in_valid = 1'b1; out_ready = 1'b0;
        step();
        wb_en = 1'b0;
        reset = 1'b1;
        step();
        chk("midrst.out_valid", 32'(out_valid), 0);
        chk("midrst.illegal_count", 32'(illegal_count), 0);
        chk("midrst.in_ready", 32'(in_ready), 0);
        reset = 1'b0; instr = 32'h001083B3; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk_bundle("postrst", mk(0, 0, 0, 1, 0, 7, 0));
        step();
        chk("postrst.drain", 32'(out_valid), 0);

        // Randomized phase against the reference model, starting from post-reset state.
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_valid = 1'b0; m_bundle = '0; m_cnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            wb_en     = $urandom_range(0, 1) == 1;
            wb_rd     = 5'($urandom_range(0, 7));
            wb_data   = $urandom;
            instr     = rand_instr();
            exp_ready = !m_valid || out_ready;
            #1 chk("rnd.in_ready", 32'(in_ready), 32'(exp_ready));
            if (in_valid && exp_ready) begin
                m_bundle = m_decode(instr, wb_en, wb_rd, wb_data);
                m_valid  = 1'b1;
                if (m_bundle.illegal && m_cnt < 65535) m_cnt++;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (wb_en && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
            step();
            chk("rnd.out_valid", 32'(out_valid), 32'(m_valid));
            chk("rnd.illegal_count", 32'(illegal_count), 32'(m_cnt));
            if (m_valid) chk_bundle("rnd", m_bundle);
        end

        // Saturation of illegal_count.
        wb_en = 1'b0; out_ready = 1'b1; in_valid = 1'b1; instr = 32'h402081B3;
        need = 65534 - m_cnt;
        repeat (need) step();
        chk("sat.fffe", 32'(illegal_count), 32'hFFFE);
        step();
        chk("sat.ffff", 32'(illegal_count), 32'hFFFF);
        repeat (5) step();
        chk("sat.hold", 32'(illegal_count), 32'hFFFF);
        chk_bundle("sat.bundle", mk(0, 0, 0, 0, 0, 3, 1));
        in_valid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
